// File: rtl/tcdm_ts_responder.sv
// rtl/tcdm_ts_responder.sv - TCDM responder for one SRAM bank with test-and-set alias and out-of-bank error
module tcdm_ts_responder #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    BE_WIDTH       = DATA_WIDTH / 8,
  parameter int                    MEM_ADDR_WIDTH = 12,
  parameter int                    BANK_WORDS     = 4096,
  parameter int                    TS_BIT         = 25,
  parameter logic [DATA_WIDTH-1:0] TS_VALUE       = '1,
  parameter logic [31:0]           ERR_DATA       = 32'hBADE5505
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_i,
  input  logic [ADDR_WIDTH-1:0]     add_i,
  input  logic                      wen_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [BE_WIDTH-1:0]       be_i,
  output logic                      gnt_o,
  output logic [DATA_WIDTH-1:0]     r_rdata_o,
  output logic                      r_valid_o,
  output logic                      error_o,
  output logic                      mem_csn_o,
  output logic                      mem_wen_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_add_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [BE_WIDTH-1:0]       mem_be_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  // Byte offset inside a word; the bank-local word offset sits between it and
  // the alias bit. Bits above TS_BIT select the bank and are decoded upstream.
  localparam int OFFS = $clog2(BE_WIDTH);
  localparam int WA_W = TS_BIT - OFFS;
  localparam logic [DATA_WIDTH-1:0] ERR_WORD = {(DATA_WIDTH / 32){ERR_DATA}};

  typedef enum logic {
    IDLE  = 1'b0,
    TS_WR = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [WA_W-1:0]           waddr;
  logic                      in_bank;
  logic                      is_ts;
  logic                      grant;
  logic                      r_valid_q;
  logic                      err_q;
  logic [MEM_ADDR_WIDTH-1:0] ts_add_q;
  logic [BE_WIDTH-1:0]       ts_be_q;
  logic                      unused_add;

  // Word offset with the alias bit dropped, so both views hit the same word.
  assign waddr   = add_i[TS_BIT-1:OFFS];
  assign in_bank = (32'(waddr) < 32'(BANK_WORDS));
  assign is_ts   = add_i[TS_BIT];
  assign grant   = req_i & gnt_o;

  // Bank-select bits and byte offset are not needed here.
  assign unused_add = ^{add_i[ADDR_WIDTH-1:TS_BIT+1], add_i[OFFS-1:0]};

  // State register; reset during TS_WR drops the pending lock write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: only an in-bank T&S read leaves IDLE, for exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant && in_bank && wen_i && is_ts) begin
          state_d = TS_WR;
        end
      end
      TS_WR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant and SRAM drive; outputs default to the incoming request so they are never X.
  always_comb begin
    gnt_o       = 1'b0;
    mem_csn_o   = 1'b1;
    mem_wen_o   = 1'b1;
    mem_add_o   = waddr[MEM_ADDR_WIDTH-1:0];
    mem_wdata_o = wdata_i;
    mem_be_o    = be_i;
    case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i && in_bank) begin
          mem_csn_o = 1'b0;
          mem_wen_o = wen_i;
        end
      end
      TS_WR: begin
        mem_csn_o   = 1'b0;
        mem_wen_o   = 1'b0;
        mem_add_o   = ts_add_q;
        mem_be_o    = ts_be_q;
        mem_wdata_o = TS_VALUE;
      end
      default: begin
        gnt_o = 1'b0;
      end
    endcase
  end

  // Response valid and error flag follow every grant by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      r_valid_q <= grant;
      err_q     <= grant & ~in_bank;
    end
  end

  // Capture the T&S target so the lock write lands on the word just read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_add_q <= '0;
      ts_be_q  <= '0;
    end else if (grant && in_bank && wen_i && is_ts) begin
      ts_add_q <= waddr[MEM_ADDR_WIDTH-1:0];
      ts_be_q  <= be_i;
    end
  end

  assign r_valid_o = r_valid_q;
  assign r_rdata_o = err_q ? ERR_WORD : mem_rdata_i;
  assign error_o   = err_q & r_valid_q;

endmodule

// File: tb/tb_tcdm_ts_responder.sv
// tb/tb_tcdm_ts_responder.sv - directed self-checking bench for tcdm_ts_responder
module tb_tcdm_ts_responder;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic [31:0] r_rdata;
  logic        r_valid;
  logic        error;
  logic        mem_csn;
  logic        mem_wen;
  logic [11:0] mem_add;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rv_cnt = 0;
  int gnt_cnt = 0;

  logic [31:0] mem [4096];

  logic [31:0] rd;
  logic        er;
  int          st;
  logic        cg;
  int          c0, r0, g0;

  tcdm_ts_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .add_i       (add),
    .wen_i       (wen),
    .wdata_i     (wdata),
    .be_i        (be),
    .gnt_o       (gnt),
    .r_rdata_o   (r_rdata),
    .r_valid_o   (r_valid),
    .error_o     (error),
    .mem_csn_o   (mem_csn),
    .mem_wen_o   (mem_wen),
    .mem_add_o   (mem_add),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM: registered read data held until the next read, byte-masked writes.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (r_valid) rv_cnt = rv_cnt + 1;
    if (req && gnt) gnt_cnt = gnt_cnt + 1;
    if (!mem_csn) begin
      if (!mem_wen) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) mem[mem_add][i*8 +: 8] <= mem_wdata[i*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_add];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Issue one access from posedge+1; returns at posedge+1 after its response.
  task automatic access(input string tag, input logic [31:0] a, input logic w,
                        input logic [31:0] d, output logic [31:0] rdo,
                        output logic ero, output int stalls, output logic csn_g);
    stalls = 0;
    req = 1'b1; add = a; wen = w; wdata = d; be = 4'hF;
    #1;
    while (!gnt && stalls < 4) begin
      @(posedge clk); #2;
      stalls++;
    end
    if (!gnt) chk({tag, "_gnt_timeout"}, 32'd0, 32'd1);
    csn_g = mem_csn;
    @(posedge clk); #1;
    chk({tag, "_rvalid"}, {31'd0, r_valid}, 32'd1);
    rdo = r_rdata;
    ero = error;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    mem_rdata = 32'd0;
    rst_n = 1'b0; req = 1'b0; add = 32'd0; wen = 1'b1; wdata = 32'd0; be = 4'hF;

    // reset state
    #3;
    chk("rst_rvalid", {31'd0, r_valid}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_csn", {31'd0, mem_csn}, 32'd1);
    chk("rst_gnt_lo", {31'd0, gnt}, 32'd0);
    req = 1'b1; add = 32'h1C00_4000; #1;
    chk("rst_gnt_follows", {31'd0, gnt}, 32'd1);
    req = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: write then read
    access("t1_wr", 32'h1C00_0010, 1'b0, 32'hCAFE0001, rd, er, st, cg);
    chk("t1_wr_stall", st, 0);
    chk("t1_wr_csn", {31'd0, cg}, 32'd0);
    access("t1_rd", 32'h1C00_0010, 1'b1, 32'd0, rd, er, st, cg);
    chk("t1_rd_data", rd, 32'hCAFE0001);
    chk("t1_rd_stall", st, 0);
    access("t1_wr0", 32'h1C00_0010, 1'b0, 32'd0, rd, er, st, cg);
    idle(1);

    // 2: T&S read of a zero word, then immediate plain re-read
    access("t2_ts", 32'h1E00_0010, 1'b1, 32'd0, rd, er, st, cg);
    chk("t2_ts_data", rd, 32'd0);
    access("t2_rd", 32'h1C00_0010, 1'b1, 32'd0, rd, er, st, cg);
    chk("t2_rd_stall", st, 1);
    chk("t2_rd_data", rd, 32'hFFFF_FFFF);
    idle(1);

    // 3: lock held, then release via T&S-alias write
    access("t3_ts", 32'h1E00_0010, 1'b1, 32'd0, rd, er, st, cg);
    chk("t3_ts_data", rd, 32'hFFFF_FFFF);
    access("t3_rel", 32'h1E00_0010, 1'b0, 32'd0, rd, er, st, cg);
    chk("t3_rel_stall", st, 1);
    access("t3_rd", 32'h1C00_0010, 1'b1, 32'd0, rd, er, st, cg);
    chk("t3_rd_stall", st, 0);
    chk("t3_rd_data", rd, 32'd0);
    idle(1);

    // 4: out-of-bank read
    access("t4_oob", 32'h1C00_4000, 1'b1, 32'd0, rd, er, st, cg);
    chk("t4_csn", {31'd0, cg}, 32'd1);
    chk("t4_data", rd, 32'hBADE5505);
    chk("t4_error", {31'd0, er}, 32'd1);
    idle(1);
    chk("t4_error_pulse", {31'd0, error}, 32'd0);
    chk("t4_rvalid_off", {31'd0, r_valid}, 32'd0);

    // 5: continuous request stream
    access("t5_p0", 32'h1C00_0020, 1'b0, 32'h1111_1111, rd, er, st, cg);
    access("t5_p1", 32'h1C00_0024, 1'b0, 32'h2222_2222, rd, er, st, cg);
    idle(1);
    c0 = cyc; r0 = rv_cnt; g0 = gnt_cnt;
    access("t5_r0", 32'h1C00_0020, 1'b1, 32'd0, rd, er, st, cg);
    chk("t5_r0_data", rd, 32'h1111_1111);
    access("t5_r1", 32'h1C00_0024, 1'b1, 32'd0, rd, er, st, cg);
    chk("t5_r1_data", rd, 32'h2222_2222);
    access("t5_r2", 32'h1C00_0028, 1'b1, 32'd0, rd, er, st, cg);
    chk("t5_r2_data", rd, 32'd0);
    access("t5_ts", 32'h1E00_0028, 1'b1, 32'd0, rd, er, st, cg);
    chk("t5_ts_data", rd, 32'd0);
    access("t5_r3", 32'h1C00_0028, 1'b1, 32'd0, rd, er, st, cg);
    chk("t5_r3_data", rd, 32'hFFFF_FFFF);
    access("t5_r4", 32'h1C00_0020, 1'b1, 32'd0, rd, er, st, cg);
    chk("t5_r4_data", rd, 32'h1111_1111);
    req = 1'b0;
    chk("t5_cycles", cyc - c0, 7);
    chk("t5_grants", gnt_cnt - g0, 6);
    @(posedge clk); #1;
    chk("t5_rvalids", rv_cnt - r0, 6);

    // 6: reset during TS_WR aborts the lock write
    access("t6_wr", 32'h1C00_0030, 1'b0, 32'h5A5A_5A5A, rd, er, st, cg);
    access("t6_ts", 32'h1E00_0030, 1'b1, 32'd0, rd, er, st, cg);
    chk("t6_ts_data", rd, 32'h5A5A_5A5A);
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rvalid", {31'd0, r_valid}, 32'd0);
    chk("t6_rst_csn", {31'd0, mem_csn}, 32'd1);
    chk("t6_rst_error", {31'd0, error}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access("t6_rd", 32'h1C00_0030, 1'b1, 32'd0, rd, er, st, cg);
    chk("t6_rd_data", rd, 32'h5A5A_5A5A);
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
